// File: rtl/mmcm_drp_reconfig_if.sv
`default_nettype none
// ============================================================================
// mmcm_drp_reconfig_if : divide-request handshake plus MMCM DRP bus
// Revision 1.0
// ============================================================================
interface mmcm_drp_reconfig_if;
   logic        reqValid_i;
   logic        reqReady_o;
   logic [6:0]  reqDivide_i;
   logic [6:0]  daddr_o;
   logic        den_o;
   logic        dwe_o;
   logic [15:0] di_o;
   logic [15:0] do_i;
   logic        drdy_i;

   // master: the reconfiguration engine (request target, DRP initiator)
   modport master (
      input  reqValid_i, reqDivide_i, do_i, drdy_i,
      output reqReady_o, daddr_o, den_o, dwe_o, di_o
   );

   // slave: the requester and the MMCM DRP port
   modport slave (
      output reqValid_i, reqDivide_i, do_i, drdy_i,
      input  reqReady_o, daddr_o, den_o, dwe_o, di_o
   );
endinterface
`default_nettype wire

// File: rtl/mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// mmcm_drp_reconfig : holds the MMCM in reset, read-modify-writes ClkReg1/2
//                     of one output divider over DRP, then waits for LOCKED
// Revision 1.0
// ============================================================================
module mmcm_drp_reconfig #(
   parameter logic [6:0] REG1_ADDR    = 7'h0A,
   parameter int         RST_HOLD     = 4,
   parameter int         DRP_TIMEOUT  = 64,
   parameter int         LOCK_TIMEOUT = 65535
) (
   input  wire                  sysClk_i,
   input  wire                  RESETn_i,
   mmcm_drp_reconfig_if.master  bus,
   output logic                 mmcmRst_o,
   input  wire                  mmcmLocked_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [1:0]           errCode_o
);

   localparam logic [3:0] S_IDLE      = 4'd0;
   localparam logic [3:0] S_RST_HOLD  = 4'd1;
   localparam logic [3:0] S_RD1       = 4'd2;
   localparam logic [3:0] S_WAIT_RD1  = 4'd3;
   localparam logic [3:0] S_WR1       = 4'd4;
   localparam logic [3:0] S_WAIT_WR1  = 4'd5;
   localparam logic [3:0] S_RD2       = 4'd6;
   localparam logic [3:0] S_WAIT_RD2  = 4'd7;
   localparam logic [3:0] S_WR2       = 4'd8;
   localparam logic [3:0] S_WAIT_WR2  = 4'd9;
   localparam logic [3:0] S_RELEASE   = 4'd10;
   localparam logic [3:0] S_WAIT_LOCK = 4'd11;
   localparam logic [3:0] S_DONE      = 4'd12;

   localparam logic [1:0] ERR_OK   = 2'd0;
   localparam logic [1:0] ERR_DIV  = 2'd1;
   localparam logic [1:0] ERR_DRP  = 2'd2;
   localparam logic [1:0] ERR_LOCK = 2'd3;

   localparam int CNT_MAX = (LOCK_TIMEOUT > DRP_TIMEOUT)
                          ? ((LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD)
                          : ((DRP_TIMEOUT  > RST_HOLD) ? DRP_TIMEOUT  : RST_HOLD);
   localparam int CW = $clog2(CNT_MAX + 1);

   logic [3:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    div_q, div_d;
   logic          drpErr_q, drpErr_d;
   logic [1:0]    errCode_q, errCode_d;
   logic [6:0]    daddr_q, daddr_d;
   logic [15:0]   di_q, di_d;
   logic          den_q, dwe_q, mmcmRst_q, busy_q, done_q, reqReady_q;
   logic          lockMeta_q, lockSync_q;

   logic [5:0]    hiCnt, loCnt;
   logic          edgeBit, noCount;

   // Divide 1 bypasses the counter: edge must be 0 and no_count 1.
   always_comb begin
      hiCnt   = div_q[6:1];
      loCnt   = div_q[5:0] - div_q[6:1];
      edgeBit = div_q[0];
      noCount = 1'b0;
      if (div_q == 7'd1) begin
         hiCnt   = 6'd1;
         loCnt   = 6'd1;
         edgeBit = 1'b0;
         noCount = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      drpErr_d  = drpErr_q;
      errCode_d = errCode_q;
      daddr_d   = daddr_q;
      di_d      = di_q;
      case (state_q)
         S_IDLE: begin
            if (bus.reqValid_i && reqReady_q) begin
               div_d     = bus.reqDivide_i;
               errCode_d = ERR_OK;
               drpErr_d  = 1'b0;
               if (bus.reqDivide_i == 7'd0 || bus.reqDivide_i == 7'd127) begin
                  state_d   = S_DONE;
                  errCode_d = ERR_DIV;
               end else begin
                  state_d = S_RST_HOLD;
                  cnt_d   = CW'(RST_HOLD - 1);
               end
            end
         end
         S_RST_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RD1;
               daddr_d = REG1_ADDR;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RD1, S_WR1, S_RD2, S_WR2: begin
            state_d = state_q + 4'd1;
            cnt_d   = CW'(1);
         end
         S_WAIT_RD1, S_WAIT_WR1, S_WAIT_RD2, S_WAIT_WR2: begin
            if (bus.drdy_i) begin
               case (state_q)
                  S_WAIT_RD1: begin
                     state_d = S_WR1;
                     di_d    = {bus.do_i[15:12], hiCnt, loCnt};
                  end
                  S_WAIT_WR1: begin
                     state_d = S_RD2;
                     daddr_d = REG1_ADDR + 7'd1;
                  end
                  S_WAIT_RD2: begin
                     state_d = S_WR2;
                     di_d    = {bus.do_i[15:8], edgeBit, noCount, bus.do_i[5:0]};
                  end
                  default: state_d = S_RELEASE;
               endcase
            end else if (cnt_q == CW'(DRP_TIMEOUT)) begin
               state_d   = S_RELEASE;
               drpErr_d  = 1'b1;
               errCode_d = ERR_DRP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RELEASE: begin
            state_d = drpErr_q ? S_DONE : S_WAIT_LOCK;
            cnt_d   = '0;
         end
         S_WAIT_LOCK: begin
            // The first three cycles may still show a stale pre-reset lock.
            if (lockSync_q && cnt_q >= CW'(3)) begin
               state_d   = S_DONE;
               errCode_d = ERR_OK;
            end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
               state_d   = S_DONE;
               errCode_d = ERR_LOCK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sysClk_i) begin
      if (!RESETn_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         div_q      <= '0;
         drpErr_q   <= 1'b0;
         errCode_q  <= ERR_OK;
         daddr_q    <= '0;
         di_q       <= '0;
         den_q      <= 1'b0;
         dwe_q      <= 1'b0;
         mmcmRst_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         reqReady_q <= 1'b0;
         lockMeta_q <= 1'b0;
         lockSync_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         drpErr_q   <= drpErr_d;
         errCode_q  <= errCode_d;
         daddr_q    <= daddr_d;
         di_q       <= di_d;
         den_q      <= (state_d inside {S_RD1, S_WR1, S_RD2, S_WR2});
         dwe_q      <= (state_d == S_WR1) || (state_d == S_WR2);
         mmcmRst_q  <= (state_d >= S_RST_HOLD) && (state_d <= S_WAIT_WR2);
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
         reqReady_q <= (state_d == S_IDLE);
         lockMeta_q <= mmcmLocked_i;
         lockSync_q <= lockMeta_q;
      end
   end

   assign bus.reqReady_o = reqReady_q;
   assign bus.daddr_o    = daddr_q;
   assign bus.den_o      = den_q;
   assign bus.dwe_o      = dwe_q;
   assign bus.di_o       = di_q;
   assign mmcmRst_o      = mmcmRst_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign errCode_o      = errCode_q;

endmodule
`default_nettype wire

// File: tb/tb_mmcm_drp_reconfig.sv
`default_nettype none
// ============================================================================
// tb_mmcm_drp_reconfig : directed bench with a DRP register/latency model and
//                        an MMCM lock model
// Revision 1.0
// ============================================================================
module tb_mmcm_drp_reconfig;
   localparam int DRP_TO  = 64;
   localparam int LOCK_TO = 300;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn;
   logic       mmcmRst, locked, busy, done;
   logic [1:0] errCode;

   mmcm_drp_reconfig_if bus();

   mmcm_drp_reconfig #(.LOCK_TIMEOUT(LOCK_TO)) dut (
      .sysClk_i    (clk),
      .RESETn_i    (rstn),
      .bus         (bus),
      .mmcmRst_o   (mmcmRst),
      .mmcmLocked_i(locked),
      .busy_o      (busy),
      .done_o      (done),
      .errCode_o   (errCode)
   );

   int nCmp = 0;
   int nErr = 0;

   // model state
   int          cyc = 0;
   int          lat = 2;
   bit          hang = 1'b0;
   int          lockDelay = 50;
   int          pend = 0;
   int          denCnt = 0;
   int          denCyc [0:255];
   int          rstCnt = 0;
   int          ovl = 0;
   int          noRst = 0;
   int          relCnt = 0;
   bit          armed = 1'b0;
   int          lockCyc = 0;
   logic [15:0] rdData = 16'h0;
   logic [15:0] mem    [0:127];
   logic [15:0] wrData [0:127];

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // DRP slave and MMCM lock behaviour, updated mid-cycle
   initial begin
      bus.drdy_i = 1'b0;
      bus.do_i   = 16'h0;
      locked     = 1'b0;
      forever begin
         @(negedge clk);
         bus.drdy_i = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               bus.drdy_i = 1'b1;
               bus.do_i   = rdData;
            end
         end
         if (bus.den_o === 1'b1) begin
            if (pend > 0 || bus.drdy_i) ovl++;
            if (!hang) pend = lat;
            if (denCnt < 256) denCyc[denCnt] = cyc;
            denCnt++;
            if (mmcmRst !== 1'b1) noRst++;
            if (bus.dwe_o === 1'b1) wrData[bus.daddr_o] = bus.di_o;
            else                    rdData = mem[bus.daddr_o];
         end
         if (mmcmRst === 1'b1) begin
            rstCnt++;
            locked = 1'b0;
            relCnt = 0;
            armed  = 1'b1;
         end else if (armed) begin
            relCnt++;
            if (relCnt == lockDelay) begin
               locked  = 1'b1;
               lockCyc = cyc;
            end
         end
      end
   end

   task automatic send_req(input logic [6:0] d, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      bus.reqValid_i  = 1'b1;
      bus.reqDivide_i = d;
      for (int i = 0; i < 50; i++) begin
         if (bus.reqReady_o === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 bus.reqValid_i = 1'b0;
   endtask

   task automatic wait_done(input int bound, output bit seen, output int waited,
                            output logic prevRst);
      seen    = 1'b0;
      waited  = 0;
      prevRst = 1'bx;
      for (int i = 0; i < bound; i++) begin
         prevRst = mmcmRst;
         @(negedge clk);
         waited++;
         if (done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic clear_wr();
      wrData[7'h0A] = 16'hDEAD;
      wrData[7'h0B] = 16'hDEAD;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      nCmp++;
      if ({bus.reqReady_o, busy, done, bus.den_o, bus.dwe_o, mmcmRst, errCode, bus.daddr_o, bus.di_o} !== '0) begin
         nErr++;
         $display("FAIL reset_outputs got rdy=%b busy=%b done=%b den=%b dwe=%b rst=%b err=%0d addr=%h di=%h want all 0",
                  bus.reqReady_o, busy, done, bus.den_o, bus.dwe_o, mmcmRst, errCode, bus.daddr_o, bus.di_o);
      end
      rstn = 1'b1;
      @(negedge clk);
      nCmp++;
      if (bus.reqReady_o !== 1'b1 || busy !== 1'b0) begin
         nErr++;
         $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", bus.reqReady_o, busy);
      end
   endtask

   task automatic test_divide40();
      bit ok, seen, denEarly;
      int waited, b;
      logic pr;
      mem[7'h0A] = 16'hF000;
      mem[7'h0B] = 16'h0000;
      lat = 2; lockDelay = 50;
      clear_wr();
      b = denCnt;
      send_req(7'd40, ok);
      nCmp++;
      if (!ok) begin nErr++; $display("FAIL d40_accept got ready never high want accepted"); end
      @(negedge clk);
      nCmp++;
      if (mmcmRst !== 1'b1 || busy !== 1'b1 || bus.reqReady_o !== 1'b0) begin
         nErr++;
         $display("FAIL d40_t1 got rst=%b busy=%b rdy=%b want 1 1 0", mmcmRst, busy, bus.reqReady_o);
      end
      denEarly = (bus.den_o !== 1'b0);
      repeat (3) begin
         @(negedge clk);
         if (bus.den_o !== 1'b0) denEarly = 1'b1;
      end
      nCmp++;
      if (denEarly || mmcmRst !== 1'b1) begin
         nErr++;
         $display("FAIL d40_hold got denEarly=%b rst@T+4=%b want 0 1", denEarly, mmcmRst);
      end
      @(negedge clk);
      nCmp++;
      if (bus.den_o !== 1'b1 || bus.daddr_o !== 7'h0A || bus.dwe_o !== 1'b0) begin
         nErr++;
         $display("FAIL d40_first_den got den=%b addr=%h dwe=%b want 1 0a 0", bus.den_o, bus.daddr_o, bus.dwe_o);
      end
      wait_done(400, seen, waited, pr);
      nCmp++;
      if (!seen || errCode !== 2'd0) begin
         nErr++;
         $display("FAIL d40_done got seen=%b code=%0d want 1 0", seen, errCode);
      end
      nCmp++;
      if (wrData[7'h0A] !== 16'hF514 || wrData[7'h0B] !== 16'h0000) begin
         nErr++;
         $display("FAIL d40_writes got r1=%h r2=%h want f514 0000", wrData[7'h0A], wrData[7'h0B]);
      end
      nCmp++;
      if (denCyc[b+1] - denCyc[b] !== 3) begin
         nErr++;
         $display("FAIL d40_drp_cost got %0d want 3", denCyc[b+1] - denCyc[b]);
      end
      nCmp++;
      if (cyc - lockCyc !== 3) begin
         nErr++;
         $display("FAIL d40_lock_latency got %0d want 3", cyc - lockCyc);
      end
      @(negedge clk);
      nCmp++;
      if (done !== 1'b0 || bus.reqReady_o !== 1'b1 || busy !== 1'b0 || errCode !== 2'd0) begin
         nErr++;
         $display("FAIL d40_after got done=%b rdy=%b busy=%b code=%0d want 0 1 0 0", done, bus.reqReady_o, busy, errCode);
      end
   endtask

   task automatic test_divide5();
      bit ok, seen;
      int waited;
      logic pr;
      mem[7'h0A] = 16'h1234;
      mem[7'h0B] = 16'hFF3F;
      clear_wr();
      send_req(7'd5, ok);
      wait_done(400, seen, waited, pr);
      nCmp++;
      if (!ok || !seen || errCode !== 2'd0) begin
         nErr++;
         $display("FAIL d5_done got ok=%b seen=%b code=%0d want 1 1 0", ok, seen, errCode);
      end
      nCmp++;
      if (wrData[7'h0A] !== 16'h1083 || wrData[7'h0B] !== 16'hFFBF) begin
         nErr++;
         $display("FAIL d5_writes got r1=%h r2=%h want 1083 ffbf", wrData[7'h0A], wrData[7'h0B]);
      end
   endtask

   task automatic test_divide1();
      bit ok, seen;
      int waited;
      logic pr;
      mem[7'h0A] = 16'hA000;
      mem[7'h0B] = 16'h0080;
      clear_wr();
      send_req(7'd1, ok);
      wait_done(400, seen, waited, pr);
      nCmp++;
      if (!ok || !seen || errCode !== 2'd0) begin
         nErr++;
         $display("FAIL d1_done got ok=%b seen=%b code=%0d want 1 1 0", ok, seen, errCode);
      end
      nCmp++;
      if (wrData[7'h0A] !== 16'hA041 || wrData[7'h0B] !== 16'h0040) begin
         nErr++;
         $display("FAIL d1_writes got r1=%h r2=%h want a041 0040", wrData[7'h0A], wrData[7'h0B]);
      end
   endtask

   task automatic test_illegal();
      bit ok;
      int d0, r0;
      logic [6:0] dv [2];
      dv[0] = 7'd0;
      dv[1] = 7'd127;
      for (int k = 0; k < 2; k++) begin
         d0 = denCnt;
         r0 = rstCnt;
         send_req(dv[k], ok);
         @(negedge clk);
         nCmp++;
         if (!ok || done !== 1'b1 || errCode !== 2'd1) begin
            nErr++;
            $display("FAIL illegal_%0d_done got ok=%b done=%b code=%0d want 1 1 1", dv[k], ok, done, errCode);
         end
         @(negedge clk);
         nCmp++;
         if (done !== 1'b0 || bus.reqReady_o !== 1'b1 || denCnt != d0 || rstCnt != r0 || errCode !== 2'd1) begin
            nErr++;
            $display("FAIL illegal_%0d_after got done=%b rdy=%b dens=%0d rstcyc=%0d code=%0d want 0 1 0 0 1",
                     dv[k], done, bus.reqReady_o, denCnt - d0, rstCnt - r0, errCode);
         end
      end
   endtask

   task automatic test_drp_timeout();
      bit ok, seen;
      int waited, b;
      logic pr;
      hang = 1'b1;
      b = denCnt;
      send_req(7'd10, ok);
      wait_done(200, seen, waited, pr);
      nCmp++;
      if (!ok || !seen || errCode !== 2'd2) begin
         nErr++;
         $display("FAIL drp_to_done got ok=%b seen=%b code=%0d want 1 1 2", ok, seen, errCode);
      end
      nCmp++;
      if (cyc - denCyc[b] < DRP_TO || cyc - denCyc[b] > DRP_TO + 3 || denCnt - b != 1) begin
         nErr++;
         $display("FAIL drp_to_timing got den->done=%0d dens=%0d want %0d..%0d and 1",
                  cyc - denCyc[b], denCnt - b, DRP_TO, DRP_TO + 3);
      end
      nCmp++;
      if (pr !== 1'b0 || mmcmRst !== 1'b0) begin
         nErr++;
         $display("FAIL drp_to_rst got before=%b at_done=%b want 0 0", pr, mmcmRst);
      end
      @(negedge clk);
      nCmp++;
      if (bus.reqReady_o !== 1'b1 || busy !== 1'b0) begin
         nErr++;
         $display("FAIL drp_to_idle got rdy=%b busy=%b want 1 0", bus.reqReady_o, busy);
      end
      hang = 1'b0;
   endtask

   task automatic test_lock_timeout();
      bit ok, seen;
      int waited;
      logic pr;
      lockDelay = 0;
      send_req(7'd20, ok);
      @(negedge clk);
      nCmp++;
      if (!ok || errCode !== 2'd0) begin
         nErr++;
         $display("FAIL lock_to_clear got ok=%b code=%0d want 1 0", ok, errCode);
      end
      wait_done(800, seen, waited, pr);
      nCmp++;
      if (!seen || errCode !== 2'd3 || waited < LOCK_TO) begin
         nErr++;
         $display("FAIL lock_to_done got seen=%b code=%0d waited=%0d want 1 3 >=%0d", seen, errCode, waited, LOCK_TO);
      end
      lockDelay = 50;
   endtask

   task automatic test_reset_midaccess();
      bit ok, seen, hit, stray;
      int waited;
      logic pr;
      lat = 10;
      send_req(7'd8, ok);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.den_o === 1'b1 && bus.dwe_o === 1'b1) begin
            hit = 1'b1;
            break;
         end
      end
      nCmp++;
      if (!ok || !hit) begin
         nErr++;
         $display("FAIL midrst_reach_wr1 got ok=%b wr1=%b want 1 1", ok, hit);
      end
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      nCmp++;
      if ({bus.den_o, mmcmRst, busy, bus.reqReady_o, done, bus.dwe_o, bus.daddr_o, bus.di_o} !== '0) begin
         nErr++;
         $display("FAIL midrst_outputs got den=%b rst=%b busy=%b rdy=%b done=%b dwe=%b addr=%h di=%h want all 0",
                  bus.den_o, mmcmRst, busy, bus.reqReady_o, done, bus.dwe_o, bus.daddr_o, bus.di_o);
      end
      rstn = 1'b1;
      stray = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (busy !== 1'b0 || bus.den_o !== 1'b0 || bus.reqReady_o !== 1'b1) stray = 1'b1;
      end
      nCmp++;
      if (stray) begin
         nErr++;
         $display("FAIL midrst_idle got activity=1 want idle with ready while stray drdy arrives");
      end
      lat = 2;
      mem[7'h0A] = 16'hF000;
      mem[7'h0B] = 16'h0000;
      clear_wr();
      send_req(7'd40, ok);
      wait_done(400, seen, waited, pr);
      nCmp++;
      if (!ok || !seen || errCode !== 2'd0 || wrData[7'h0A] !== 16'hF514 || wrData[7'h0B] !== 16'h0000) begin
         nErr++;
         $display("FAIL midrst_new_req got ok=%b seen=%b code=%0d r1=%h r2=%h want 1 1 0 f514 0000",
                  ok, seen, errCode, wrData[7'h0A], wrData[7'h0B]);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got time limit reached want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rstn            = 1'b0;
      bus.reqValid_i  = 1'b0;
      bus.reqDivide_i = 7'd0;
      for (int i = 0; i < 128; i++) begin
         mem[i]    = 16'h0;
         wrData[i] = 16'h0;
      end
      test_reset();
      test_divide40();
      test_divide5();
      test_divide1();
      test_illegal();
      test_drp_timeout();
      test_lock_timeout();
      test_reset_midaccess();
      nCmp++;
      if (ovl != 0 || noRst != 0) begin
         nErr++;
         $display("FAIL drp_protocol got overlaps=%0d den_without_rst=%0d want 0 0", ovl, noRst);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule
`default_nettype wire
